// File: rtl/serdes_tx_lanes.sv
// +----------------------------------------------------------------------------+
// | serdes_tx_lanes : multi-lane word-to-bit serialiser with training and idle  |
// | fill, valid/ready word handshake, gapless back-to-back words.               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module serdes_tx_lanes #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      LANES      = 1,
  parameter bit               LSB_FIRST  = 1'b1,
  parameter logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(8'hF0),
  parameter logic             IDLE_BIT   = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   train,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [LANES-1:0]       ser_data,
  output logic                   ser_frame,
  output logic                   underflow
);

  localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   active_q, active_d;
  logic [LANES*WIDTH-1:0] sr_q, sr_d;
  logic [LANES-1:0]       ser_q, ser_d;
  logic                   frame_q, frame_d;
  logic                   under_q, under_d;
  logic                   load_slot;
  logic [LANES*WIDTH-1:0] word_sel;

  assign load_slot  = ~active_q | (cnt_q == CNT_LAST);
  assign data_ready = load_slot & en & ~train & ~rst;

  // Disabled and idle-fill both load an all-IDLE_BIT word, so the line level
  // while disabled falls out of the same shift path.
  always_comb begin
    word_sel = {(LANES*WIDTH){IDLE_BIT}};
    if (en) begin
      if (train)
        word_sel = {LANES{TRAIN_WORD}};
      else if (data_valid)
        word_sel = data_in;
    end
  end

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    active_d = active_q;
    frame_d  = 1'b0;
    under_d  = 1'b0;
    if (load_slot) begin
      cnt_d = '0;
      if (!en) begin
        active_d = 1'b0;
      end else begin
        active_d = 1'b1;
        if (train || data_valid)
          frame_d = 1'b1;
        else
          under_d = 1'b1;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] src;
    assign src = load_slot ? word_sel[l*WIDTH +: WIDTH] : sr_q[l*WIDTH +: WIDTH];
    if (LSB_FIRST) begin : g_lsb
      assign ser_d[l]                = src[0];
      assign sr_d[l*WIDTH +: WIDTH]  = {IDLE_BIT, src[WIDTH-1:1]};
    end else begin : g_msb
      assign ser_d[l]                = src[WIDTH-1];
      assign sr_d[l*WIDTH +: WIDTH]  = {src[WIDTH-2:0], IDLE_BIT};
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      sr_q     <= {(LANES*WIDTH){IDLE_BIT}};
      ser_q    <= {LANES{IDLE_BIT}};
      frame_q  <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      sr_q     <= sr_d;
      ser_q    <= ser_d;
      frame_q  <= frame_d;
      under_q  <= under_d;
    end
  end

  assign ser_data  = ser_q;
  assign ser_frame = frame_q;
  assign underflow = under_q;

endmodule

`default_nettype wire

// File: tb/tb_serdes_tx_lanes.sv
// Directed bench for serdes_tx_lanes: one LSB-first and one MSB-first instance
// share all inputs; expected per-lane bit sequences are hand-computed constants.
`default_nettype none

module tb_serdes_tx_lanes;

  localparam int KIND_DATA = 0;
  localparam int KIND_FILL = 1;
  localparam int KIND_OFF  = 2;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic        train;
  logic [15:0] data_in;
  logic        data_valid;
  logic        rdy_l, rdy_m;
  logic [1:0]  ser_l, ser_m;
  logic        frame_l, frame_m;
  logic        under_l, under_m;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  serdes_tx_lanes #(
    .WIDTH(8), .LANES(2), .LSB_FIRST(1'b1), .TRAIN_WORD(8'hF0), .IDLE_BIT(1'b0)
  ) dut_lsb (
    .clk_in(clk_in), .rst(rst), .en(en), .train(train), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy_l), .ser_data(ser_l),
    .ser_frame(frame_l), .underflow(under_l)
  );

  serdes_tx_lanes #(
    .WIDTH(8), .LANES(2), .LSB_FIRST(1'b0), .TRAIN_WORD(8'hF0), .IDLE_BIT(1'b0)
  ) dut_msb (
    .clk_in(clk_in), .rst(rst), .en(en), .train(train), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy_m), .ser_data(ser_m),
    .ser_frame(frame_m), .underflow(under_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq_* bit k (lane0) / bit 8+k (lane1) is the k-th transmitted bit.
  // After the k==2 sample the mid-word inputs are applied and data_in scrambled.
  task automatic word(input string tag, input logic [15:0] seq_l, input logic [15:0] seq_m,
                      input int kind, input logic dv_mid, input logic tr_mid, input logic rdy7);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      chk($sformatf("%s.lsb.b%0d", tag, k), 32'(ser_l), 32'({seq_l[8+k], seq_l[k]}));
      chk($sformatf("%s.msb.b%0d", tag, k), 32'(ser_m), 32'({seq_m[8+k], seq_m[k]}));
      chk($sformatf("%s.frame.b%0d", tag, k), 32'({frame_m, frame_l}),
          (kind == KIND_DATA && k == 0) ? 32'd3 : 32'd0);
      chk($sformatf("%s.under.b%0d", tag, k), 32'({under_m, under_l}),
          (kind == KIND_FILL && k == 0) ? 32'd3 : 32'd0);
      chk($sformatf("%s.rdy.b%0d", tag, k), 32'({rdy_m, rdy_l}),
          (kind != KIND_OFF && k == 7 && rdy7) ? 32'd3 : 32'd0);
      if (k == 2) begin
        data_valid = dv_mid;
        train      = tr_mid;
        data_in    = ~data_in;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; train = 1'b0; data_valid = 1'b0; data_in = 16'h0000;
    repeat (2) @(negedge clk_in);
    chk("rst.ser", 32'({ser_m, ser_l}), 32'd0);
    chk("rst.flags", 32'({frame_l, under_l, frame_m, under_m}), 32'd0);
    en = 1'b1; #1;
    chk("rst.rdy", 32'({rdy_m, rdy_l}), 32'd0);
    en = 1'b0;

    @(negedge clk_in);
    rst = 1'b0; #1;
    chk("off.rdy", 32'(rdy_l), 32'd0);
    @(negedge clk_in);
    chk("off.ser", 32'({ser_m, ser_l}), 32'd0);

    // single word, then two idle-fill words
    en = 1'b1; data_valid = 1'b1; data_in = 16'hA53C; #1;
    chk("en_rise.rdy", 32'(rdy_l), 32'd1);
    word("a53c", 16'hA53C, 16'hA53C, KIND_DATA, 1'b0, 1'b0, 1'b1);
    word("fill0", 16'h0000, 16'h0000, KIND_FILL, 1'b0, 1'b0, 1'b1);
    word("fill1", 16'h0000, 16'h0000, KIND_FILL, 1'b0, 1'b0, 1'b1);

    // four-word stream with data_valid held high
    data_valid = 1'b1; data_in = 16'h1E07;
    word("s0", 16'h1E07, 16'h78E0, KIND_DATA, 1'b1, 1'b0, 1'b1);
    data_in = 16'h8001;
    word("s1", 16'h8001, 16'h0180, KIND_DATA, 1'b1, 1'b0, 1'b1);
    data_in = 16'h0F55;
    word("s2", 16'h0F55, 16'hF0AA, KIND_DATA, 1'b1, 1'b0, 1'b1);
    data_in = 16'hC3A6;
    word("s3", 16'hC3A6, 16'hC365, KIND_DATA, 1'b0, 1'b0, 1'b1);

    // training: pattern repeats, cleared mid-word on the third repetition
    train = 1'b1; #1;
    chk("train.rdy", 32'(rdy_l), 32'd0);
    word("tr0", 16'hF0F0, 16'h0F0F, KIND_DATA, 1'b0, 1'b1, 1'b0);
    word("tr1", 16'hF0F0, 16'h0F0F, KIND_DATA, 1'b0, 1'b1, 1'b0);
    word("tr2", 16'hF0F0, 16'h0F0F, KIND_DATA, 1'b0, 1'b0, 1'b1);

    // reset at cnt=3 of a word
    data_valid = 1'b1; data_in = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("pre_rst.b%0d", k), 32'({ser_m, ser_l}), 32'hF);
    end
    rst = 1'b1; data_valid = 1'b0; en = 1'b0; #1;
    chk("mid_rst.ser", 32'({ser_m, ser_l}), 32'd0);
    chk("mid_rst.flags", 32'({frame_l, under_l, frame_m, under_m}), 32'd0);
    chk("mid_rst.rdy", 32'(rdy_l), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      chk("post_rst.idle", 32'({ser_m, ser_l, frame_l, under_l}), 32'd0);
    end
    en = 1'b1; data_valid = 1'b1; data_in = 16'h8001;
    word("post", 16'h8001, 16'h0180, KIND_DATA, 1'b0, 1'b0, 1'b1);

    // disable at the word boundary: line stays idle, no fill
    en = 1'b0;
    word("dis", 16'h0000, 16'h0000, KIND_OFF, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
